// File: rtl/lsu_bus.sv
// lsu_bus: load/store unit bus bridge.
// Takes one core access at a time, checks size/alignment, runs a single bus
// cycle with an acknowledge timeout, and returns extended load data or a fault.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_*               core request (valid/ready handshake, fields captured at acceptance)
//   resp_*              one-cycle response pulse with data, fault flag and cause
//   DAD, DDT_out, MREQ,
//   WRITE, SIZE         bus address, lane-aligned store data, request strobe, direction, size
//   DDT_in, ACKD_n      bus read data and active-low acknowledge
//
// state | meaning
// IDLE  | ready for a new access
// BUS   | bus cycle in progress, waiting for ACKD_n or timeout
// RESP  | one-cycle response pulse, then back to IDLE
module lsu_bus #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [1:0]      resp_cause,
  output logic [XLEN-1:0] DAD,
  output logic [XLEN-1:0] DDT_out,
  input  logic [XLEN-1:0] DDT_in,
  output logic            MREQ,
  output logic            WRITE,
  output logic [1:0]      SIZE,
  input  logic            ACKD_n
);

  localparam int L = (XLEN == 64) ? 3 : 2;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_SIZE    = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t state_q, state_d;

  logic            write_q;
  logic [1:0]      size_q;
  logic            unsigned_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [7:0]      cnt_q;

  logic accept;
  logic unsupported;
  logic misaligned;
  logic [2:0] align_mask;

  assign accept = (state_q == IDLE) && req_valid;

  always_comb begin
    case (req_size)
      2'b00:   align_mask = 3'b000;
      2'b01:   align_mask = 3'b001;
      2'b10:   align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  end

  assign unsupported = (req_size == 2'b11) && (XLEN == 32);
  assign misaligned  = (req_addr[2:0] & align_mask) != 3'b000;

  // Load extraction: bring the addressed lane down to bit 0, then extend.
  logic [XLEN-1:0] rd_shifted;
  logic [XLEN-1:0] rd_mask;
  logic            rd_sign;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    rd_shifted = DDT_in >> {addr_q[L-1:0], 3'b000};
    case (size_q)
      2'b00: begin
        rd_mask = XLEN'(8'hFF);
        rd_sign = rd_shifted[7];
      end
      2'b01: begin
        rd_mask = XLEN'(16'hFFFF);
        rd_sign = rd_shifted[15];
      end
      2'b10: begin
        rd_mask = XLEN'(32'hFFFF_FFFF);
        rd_sign = rd_shifted[31];
      end
      default: begin
        rd_mask = '1;
        rd_sign = rd_shifted[XLEN-1];
      end
    endcase
    load_ext = (rd_shifted & rd_mask) | ((rd_sign && !unsigned_q) ? ~rd_mask : '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) state_d = (unsupported || misaligned) ? RESP : BUS;
      end
      BUS: begin
        if (!ACKD_n || (cnt_q == 8'd0)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and timeout down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= 8'd0;
    end else if (accept) begin
      write_q    <= req_write;
      size_q     <= req_size;
      unsigned_q <= req_unsigned;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      cnt_q      <= 8'(TIMEOUT - 1);
    end else if ((state_q == BUS) && ACKD_n && (cnt_q != 8'd0)) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  // Output logic: next values of the registered outputs. On the acceptance
  // edge the request registers are not loaded yet, so the bus fields are
  // taken straight from the request inputs.
  logic            src_write;
  logic [1:0]      src_size;
  logic [XLEN-1:0] src_addr;
  logic [XLEN-1:0] src_wdata;

  logic            req_ready_d;
  logic            resp_valid_d;
  logic [XLEN-1:0] resp_rdata_d;
  logic            resp_fault_d;
  logic [1:0]      resp_cause_d;
  logic [XLEN-1:0] dad_d;
  logic [XLEN-1:0] ddt_out_d;
  logic            mreq_d;
  logic            write_d;
  logic [1:0]      size_d;

  always_comb begin
    src_write = (state_q == IDLE) ? req_write : write_q;
    src_size  = (state_q == IDLE) ? req_size  : size_q;
    src_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    src_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_fault_d = 1'b0;
    resp_cause_d = CAUSE_NONE;
    dad_d        = '0;
    ddt_out_d    = '0;
    mreq_d       = 1'b0;
    write_d      = 1'b0;
    size_d       = 2'b00;

    if (state_d == BUS) begin
      mreq_d    = 1'b1;
      write_d   = src_write;
      size_d    = src_size;
      dad_d     = src_addr;
      ddt_out_d = src_wdata << {src_addr[L-1:0], 3'b000};
    end

    if (state_d == RESP) begin
      resp_valid_d = 1'b1;
      if (state_q == IDLE) begin
        resp_fault_d = 1'b1;
        resp_cause_d = unsupported ? CAUSE_SIZE : CAUSE_MISALIGN;
      end else if (!ACKD_n) begin
        resp_rdata_d = write_q ? '0 : load_ext;
      end else begin
        resp_fault_d = 1'b1;
        resp_cause_d = CAUSE_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      resp_cause <= CAUSE_NONE;
      DAD        <= '0;
      DDT_out    <= '0;
      MREQ       <= 1'b0;
      WRITE      <= 1'b0;
      SIZE       <= 2'b00;
    end else begin
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_fault <= resp_fault_d;
      resp_cause <= resp_cause_d;
      DAD        <= dad_d;
      DDT_out    <= ddt_out_d;
      MREQ       <= mreq_d;
      WRITE      <= write_d;
      SIZE       <= size_d;
    end
  end

endmodule

// File: tb/tb_lsu_bus.sv
module tb_lsu_bus;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 32-bit instance
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  logic [31:0] dad, ddt_out, ddt_in;
  logic        mreq, write, ackd_n;
  logic [1:0]  size;

  // 64-bit instance
  logic        req_valid_64, req_ready_64, req_write_64, req_unsigned_64;
  logic [1:0]  req_size_64;
  logic [63:0] req_addr_64, req_wdata_64;
  logic        resp_valid_64, resp_fault_64;
  logic [63:0] resp_rdata_64;
  logic [1:0]  resp_cause_64;
  logic [63:0] dad_64, ddt_out_64, ddt_in_64;
  logic        mreq_64, write_64, ackd_n_64;
  logic [1:0]  size_64;

  lsu_bus #(.XLEN(32), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .resp_cause(resp_cause),
    .DAD(dad), .DDT_out(ddt_out), .DDT_in(ddt_in), .MREQ(mreq),
    .WRITE(write), .SIZE(size), .ACKD_n(ackd_n)
  );

  lsu_bus #(.XLEN(64), .TIMEOUT(4)) u_dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_64), .req_ready(req_ready_64), .req_write(req_write_64),
    .req_size(req_size_64), .req_unsigned(req_unsigned_64), .req_addr(req_addr_64),
    .req_wdata(req_wdata_64), .resp_valid(resp_valid_64), .resp_rdata(resp_rdata_64),
    .resp_fault(resp_fault_64), .resp_cause(resp_cause_64),
    .DAD(dad_64), .DDT_out(ddt_out_64), .DDT_in(ddt_in_64), .MREQ(mreq_64),
    .WRITE(write_64), .SIZE(size_64), .ACKD_n(ackd_n_64)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  exp_t sb32[$];
  exp_t sb64[$];

  int n_checks = 0;
  int n_pass   = 0;

  // One access on the 32-bit unit. ack_cyc is the BUS cycle whose closing
  // edge sees ACKD_n=0 (0 = never acknowledge).
  task automatic access32(input string name, input logic w, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                          input int ack_cyc, input logic [31:0] din,
                          input int exp_lat, input int exp_mreq, input logic [31:0] exp_ddt,
                          input logic [31:0] exp_rdata, input logic exp_fault,
                          input logic [1:0] exp_cause);
    exp_t e;
    int lat, nmreq;
    bit got;
    logic [31:0] s_dad, s_ddt;
    logic [1:0]  s_size;
    logic        s_write;
    sb32.push_back('{rdata: {32'h0, exp_rdata}, fault: exp_fault, cause: exp_cause});
    lat = 0; nmreq = 0; got = 0;
    s_dad = '0; s_ddt = '0; s_size = '0; s_write = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL %s ready: got %b want 1", name, req_ready);
    else n_pass++;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (mreq) begin
        nmreq++;
        if (nmreq == 1) begin
          s_dad = dad; s_ddt = ddt_out; s_size = size; s_write = write;
        end
        ackd_n = (nmreq == ack_cyc) ? 1'b0 : 1'b1;
        ddt_in = (nmreq == ack_cyc) ? din : $urandom;
      end else begin
        ackd_n = 1'b1;
      end
      if (resp_valid) begin
        got = 1;
        lat = k;
        e = sb32.pop_front();
        n_checks++;
        if (lat !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        else n_pass++;
        n_checks++;
        if (nmreq !== exp_mreq) $display("FAIL %s mreq_cycles: got %0d want %0d", name, nmreq, exp_mreq);
        else n_pass++;
        n_checks++;
        if (resp_rdata !== e.rdata[31:0]) $display("FAIL %s rdata: got %h want %h", name, resp_rdata, e.rdata[31:0]);
        else n_pass++;
        n_checks++;
        if ({resp_fault, resp_cause} !== {e.fault, e.cause})
          $display("FAIL %s fault/cause: got %b/%b want %b/%b", name, resp_fault, resp_cause, e.fault, e.cause);
        else n_pass++;
        if (exp_mreq > 0) begin
          n_checks++;
          if ({s_dad, s_ddt, s_size, s_write} !== {addr, exp_ddt, sz, w})
            $display("FAIL %s bus_fields: got dad=%h ddt=%h size=%b write=%b want dad=%h ddt=%h size=%b write=%b",
                     name, s_dad, s_ddt, s_size, s_write, addr, exp_ddt, sz, w);
          else n_pass++;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL %s no_response: got none within 40 cycles want resp_valid", name);
      if (sb32.size() > 0) void'(sb32.pop_front());
    end
    ackd_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({resp_valid, mreq} !== 2'b00) $display("FAIL %s pulse_end: got valid=%b mreq=%b want 0/0", name, resp_valid, mreq);
    else n_pass++;
  endtask

  // One access on the 64-bit unit; acknowledged in the first BUS cycle.
  task automatic access64(input string name, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] din, input int exp_lat,
                          input logic [63:0] exp_rdata, input logic exp_fault,
                          input logic [1:0] exp_cause);
    exp_t e;
    bit got;
    got = 0;
    sb64.push_back('{rdata: exp_rdata, fault: exp_fault, cause: exp_cause});
    @(posedge clk); #1;
    req_valid_64 = 1'b1; req_write_64 = 1'b0; req_size_64 = sz; req_unsigned_64 = uns;
    req_addr_64 = addr; req_wdata_64 = '0;
    @(posedge clk); #1;
    req_valid_64 = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      ackd_n_64 = mreq_64 ? 1'b0 : 1'b1;
      ddt_in_64 = din;
      if (resp_valid_64) begin
        got = 1;
        e = sb64.pop_front();
        n_checks++;
        if (k !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, k, exp_lat);
        else n_pass++;
        n_checks++;
        if ({resp_rdata_64, resp_fault_64, resp_cause_64} !== {e.rdata, e.fault, e.cause})
          $display("FAIL %s resp: got %h/%b/%b want %h/%b/%b", name, resp_rdata_64, resp_fault_64,
                   resp_cause_64, e.rdata, e.fault, e.cause);
        else n_pass++;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL %s no_response: got none within 40 cycles want resp_valid", name);
      if (sb64.size() > 0) void'(sb64.pop_front());
    end
    ackd_n_64 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({req_ready, mreq, write, size, resp_valid, resp_fault, resp_cause} !== 9'b1_0_0_00_0_0_00)
      $display("FAIL reset_ctrl32: got rdy=%b mreq=%b wr=%b size=%b v=%b f=%b c=%b want 1/0/0/00/0/0/00",
               req_ready, mreq, write, size, resp_valid, resp_fault, resp_cause);
    else n_pass++;
    n_checks++;
    if ({dad, ddt_out, resp_rdata} !== 96'h0)
      $display("FAIL reset_data32: got dad=%h ddt=%h rdata=%h want 0", dad, ddt_out, resp_rdata);
    else n_pass++;
    n_checks++;
    if ({req_ready_64, mreq_64, resp_valid_64, resp_cause_64, dad_64, ddt_out_64, resp_rdata_64} !==
        {1'b1, 1'b0, 1'b0, 2'b00, 192'h0})
      $display("FAIL reset_64: got rdy=%b mreq=%b v=%b c=%b dad=%h want 1/0/0/00/0",
               req_ready_64, mreq_64, resp_valid_64, resp_cause_64, dad_64);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_load_sign();
    access32("lb_signed", 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 1, 32'h80FF_FFFF,
             2, 1, 32'h0, 32'hFFFF_FF80, 1'b0, 2'b00);
    access32("lh_unsigned", 1'b0, 2'b01, 1'b1, 32'h0002, 32'h0, 1, 32'h8001_1234,
             2, 1, 32'h0, 32'h0000_8001, 1'b0, 2'b00);
    access32("lh_signed", 1'b0, 2'b01, 1'b0, 32'h0002, 32'h0, 1, 32'h8001_1234,
             2, 1, 32'h0, 32'hFFFF_8001, 1'b0, 2'b00);
  endtask

  task automatic test_store_lanes();
    access32("sh_lanes", 1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_ABCD, 1, 32'hFFFF_FFFF,
             2, 1, 32'hABCD_0000, 32'h0, 1'b0, 2'b00);
    access32("sb_lanes", 1'b1, 2'b00, 1'b0, 32'h0001, 32'h0000_005A, 1, 32'h1234_5678,
             2, 1, 32'h0000_5A00, 32'h0, 1'b0, 2'b00);
  endtask

  task automatic test_misaligned();
    access32("lw_misalign", 1'b0, 2'b10, 1'b0, 32'h1002, 32'h0, 1, 32'h1111_1111,
             1, 0, 32'h0, 32'h0, 1'b1, 2'b01);
    access32("sh_misalign", 1'b1, 2'b01, 1'b0, 32'h1001, 32'h1234, 1, 32'h0,
             1, 0, 32'h0, 32'h0, 1'b1, 2'b01);
  endtask

  task automatic test_timeout();
    access32("timeout", 1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 0, 32'h0,
             5, 4, 32'h0, 32'h0, 1'b1, 2'b10);
    access32("ack_last_cycle", 1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 4, 32'h1234_5678,
             5, 4, 32'h0, 32'h1234_5678, 1'b0, 2'b00);
  endtask

  task automatic test_unsupported();
    access32("size11", 1'b0, 2'b11, 1'b0, 32'h1000, 32'h0, 1, 32'h0,
             1, 0, 32'h0, 32'h0, 1'b1, 2'b11);
    access32("size11_misalign", 1'b1, 2'b11, 1'b0, 32'h1001, 32'h0, 1, 32'h0,
             1, 0, 32'h0, 32'h0, 1'b1, 2'b11);
  endtask

  task automatic test_xlen64();
    access64("lwu64", 2'b10, 1'b1, 64'h1004, 64'h8000_0001_0000_0000, 2,
             64'h0000_0000_8000_0001, 1'b0, 2'b00);
    access64("lw64", 2'b10, 1'b0, 64'h1004, 64'h8000_0001_0000_0000, 2,
             64'hFFFF_FFFF_8000_0001, 1'b0, 2'b00);
    access64("ld64", 2'b11, 1'b0, 64'h2008, 64'h0123_4567_89AB_CDEF, 2,
             64'h0123_4567_89AB_CDEF, 1'b0, 2'b00);
    access64("ld64_misalign", 2'b11, 1'b0, 64'h2004, 64'h0, 1,
             64'h0, 1'b1, 2'b01);
  endtask

  task automatic test_reset_during_bus();
    bit bad;
    bad = 0;
    ackd_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h4000; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if (mreq !== 1'b1) $display("FAIL rst_bus_in_bus: got mreq=%b want 1", mreq);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({req_ready, mreq, write, size, resp_valid, resp_fault, resp_cause, dad, ddt_out, resp_rdata} !==
        {9'b1_0_0_00_0_0_00, 96'h0})
      $display("FAIL rst_bus_outputs: got rdy=%b mreq=%b v=%b dad=%h want 1/0/0/0",
               req_ready, mreq, resp_valid, dad);
    else n_pass++;
    repeat (8) begin
      @(posedge clk); #1;
      if (resp_valid || mreq) bad = 1;
    end
    n_checks++;
    if (bad) $display("FAIL rst_bus_no_resp: got resp_valid/mreq after abort want none");
    else n_pass++;
    access32("after_reset", 1'b0, 2'b10, 1'b0, 32'h4000, 32'h0, 1, 32'hCAFE_F00D,
             2, 1, 32'h0, 32'hCAFE_F00D, 1'b0, 2'b00);
  endtask

  task automatic test_back_to_back();
    // ACKD_n low while idle must not be taken as an acknowledge.
    ackd_n = 1'b0;
    repeat (2) @(posedge clk);
    access32("idle_ack_ignored", 1'b0, 2'b00, 1'b1, 32'h0007, 32'h0, 2, 32'hF000_0000,
             3, 2, 32'h0, 32'h0000_00F0, 1'b0, 2'b00);
    access32("b2b_fault", 1'b0, 2'b01, 1'b0, 32'h0003, 32'h0, 1, 32'h0,
             1, 0, 32'h0, 32'h0, 1'b1, 2'b01);
    access32("b2b_store", 1'b1, 2'b10, 1'b0, 32'h0004, 32'hDEAD_BEEF, 1, 32'h5555_5555,
             2, 1, 32'hDEAD_BEEF, 32'h0, 1'b0, 2'b00);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; ddt_in = '0; ackd_n = 1'b1;
    req_valid_64 = 1'b0; req_write_64 = 1'b0; req_size_64 = 2'b00; req_unsigned_64 = 1'b0;
    req_addr_64 = '0; req_wdata_64 = '0; ddt_in_64 = '0; ackd_n_64 = 1'b1;

    test_reset();
    test_load_sign();
    test_store_lanes();
    test_misaligned();
    test_timeout();
    test_unsupported();
    test_xlen64();
    test_reset_during_bus();
    test_back_to_back();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_bus.md
LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 SHALL have parameter: XLEN, 32, datapath and address width; legal values 32 or 64.
REQ-002 SHALL have parameter: TIMEOUT, 16, maximum BUS cycles without acknowledge; range 2..255.
REQ-003 SHALL have port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: req_valid  input  1  core presents an access.
REQ-006 SHALL have port: req_ready  output  1  unit can accept an access.
REQ-007 SHALL have port: req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port: req_size  input  2  00 byte, 01 half, 10 word, 11 double.
REQ-009 SHALL have port: req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port: req_addr  input  XLEN  byte address.
REQ-011 SHALL have port: req_wdata  input  XLEN  store data, right-aligned.
REQ-012 SHALL have port: resp_valid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port: resp_rdata  output  XLEN  extended load data; 0 for stores and faults.
REQ-014 SHALL have port: resp_fault  output  1  access failed.
REQ-015 SHALL have port: resp_cause  output  2  00 none, 01 misaligned, 10 timeout, 11 unsupported size.
REQ-016 SHALL have ports: DAD  output  XLEN; DDT_out  output  XLEN; DDT_in  input  XLEN; MREQ  output  1; WRITE  output  1; SIZE  output  2; ACKD_n  input  1 (active-low acknowledge).

Function
REQ-017 SHALL implement FSM states IDLE, BUS, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL accept an access on an edge where req_valid && req_ready; all request fields are registered at acceptance.
REQ-019 SHALL on acceptance go to RESP with resp_fault=1 and no bus cycle when: req_size=11 with XLEN=32 (cause 11); else address not aligned to 2^req_size bytes (cause 01). Unsupported size takes priority.
REQ-020 SHALL otherwise go to BUS, driving MREQ=1, WRITE=req_write, SIZE=req_size, DAD=req_addr from registers for every BUS cycle.
REQ-021 SHALL place store data in byte lanes: DDT_out = req_wdata shifted left by 8*addr[L-1:0], L = log2(XLEN/8); DDT_out = 0 outside BUS.
REQ-022 SHALL sample ACKD_n only in BUS; ACKD_n=0 at an edge ends BUS, captures DDT_in, moves to RESP.
REQ-023 SHALL count BUS cycles; if TIMEOUT cycles elapse with ACKD_n=1 at each edge, go to RESP with resp_fault=1, cause 10; acknowledge in the TIMEOUT-th cycle wins over timeout.
REQ-024 SHALL assert resp_valid for exactly the one RESP cycle, then return to IDLE; ACKD_n during IDLE/RESP ignored.
REQ-025 SHALL for loads shift captured data right by 8*addr[L-1:0], keep 8<<req_size bits, sign- or zero-extend to XLEN.
REQ-026 SHALL give latency: acknowledge in first BUS cycle -> resp_valid 2 cycles after acceptance edge; fault at acceptance -> resp_valid 1 cycle after.
REQ-027 SHALL register all outputs; no combinational path from inputs to outputs except none.

Reset
REQ-028 SHALL on rst=1 at an edge enter IDLE; req_ready=1, MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT_out=0, resp_valid=0, resp_rdata=0, resp_fault=0, resp_cause=00, counter=0.
REQ-029 SHALL when reset hits during BUS drop MREQ next cycle and produce no resp_valid for the aborted access.

Verification
REQ-030 XLEN=32, signed byte load addr 0x1003, ACKD_n=0 first BUS cycle, DDT_in=0x80FFFFFF -> SIZE=00, resp_rdata=0xFFFFFF80, resp_valid 2 cycles after accept.
REQ-031 Half store addr 0x2002, req_wdata=0x0000ABCD -> DDT_out=0xABCD0000, WRITE=1, SIZE=01, resp_fault=0, resp_rdata=0.
REQ-032 Word load addr 0x1002 -> MREQ never high, resp_valid 1 cycle after accept, resp_fault=1, resp_cause=01.
REQ-033 TIMEOUT=4, ACKD_n held 1 -> MREQ high exactly 4 cycles, then resp_cause=10; repeat with ACKD_n=0 in 4th cycle -> cause 00, data captured.
REQ-034 XLEN=32, req_size=11 -> resp_cause=11, no bus cycle; XLEN=64 unsigned word load addr 0x...4, DDT_in=0x8000000100000000 -> resp_rdata=0x0000000080000001.
REQ-035 rst=1 during 3rd BUS cycle -> all outputs at reset values next cycle, no resp_valid, next request served normally.
